divider_32bit: RTL and testbench

Iterative 32-bit integer divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions. It complements the single-cycle ALU with the inverse of its multiply path. The unit runs a radix-2 restoring shift-subtract loop over a multi-cycle start/busy/done handshake. The core holds the instruction while `busy` is high.

---
 rtl/divider_32bit.sv | 131 +++++++++++++
 tb/tb_divider_32bit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/divider_32bit.sv
// ============================================================================
// Module  : divider_32bit
// Brief   : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        dz
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_calc = 2'd1;
  localparam logic [1:0] c_fix  = 2'd2;
  localparam logic [1:0] c_done = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  r_op;
  logic        r_neg_a;
  logic        r_neg_b;
  logic [31:0] r_q;
  logic [32:0] r_rem;
  logic [31:0] r_div;
  logic [5:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_dz;
  logic        r_dz_pend;

  // op[0] set means unsigned; op[1] set selects the remainder
  logic        w_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_bz;
  logic        w_ovf;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_quo;
  logic [31:0] w_rmd;

  assign w_signed = ~op[0];
  assign w_neg_a  = w_signed & a[31];
  assign w_neg_b  = w_signed & b[31];
  assign w_mag_a  = w_neg_a ? (~a + 32'd1) : a;
  assign w_mag_b  = w_neg_b ? (~b + 32'd1) : b;
  assign w_bz     = (b == 32'd0);
  assign w_ovf    = w_signed & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);

  assign w_shift  = {r_rem[31:0], r_q[31]};
  assign w_ge     = (w_shift >= {1'b0, r_div});

  assign w_quo = (~r_op[0] & (r_neg_a ^ r_neg_b)) ? (~r_q + 32'd1) : r_q;
  assign w_rmd = (~r_op[0] & r_neg_a) ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_op      <= 2'd0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_q       <= 32'd0;
      r_rem     <= 33'd0;
      r_div     <= 32'd0;
      r_cnt     <= 6'd0;
      r_result  <= 32'd0;
      r_dz      <= 1'b0;
      r_dz_pend <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_op    <= op;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_div   <= w_mag_b;
            r_cnt   <= 6'd0;
            if (w_bz || w_ovf) begin
              // Special cases bypass the loop; q/rem registers carry the answer
              r_state   <= c_fix;
              r_q       <= w_bz ? 32'hFFFF_FFFF : 32'h8000_0000;
              r_rem     <= w_bz ? {1'b0, a} : 33'd0;
              r_dz_pend <= w_bz;
            end else begin
              r_state   <= c_calc;
              r_q       <= w_mag_a;
              r_rem     <= 33'd0;
              r_dz_pend <= 1'b0;
            end
          end
        end
        c_calc: begin
          if (r_cnt == 6'd32) begin
            r_result <= r_op[1] ? w_rmd : w_quo;
            r_dz     <= 1'b0;
            r_state  <= c_done;
          end else begin
            r_rem <= w_ge ? (w_shift - {1'b0, r_div}) : w_shift;
            r_q   <= {r_q[30:0], w_ge};
            r_cnt <= r_cnt + 6'd1;
          end
        end
        c_fix: begin
          r_result <= r_op[1] ? r_rem[31:0] : r_q;
          r_dz     <= r_dz_pend;
          r_state  <= c_done;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign busy   = (r_state == c_calc) || (r_state == c_fix);
  assign done   = (r_state == c_done);
  assign result = r_result;
  assign dz     = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_divider_32bit.sv
// ============================================================================
// Module  : tb_divider_32bit
// Brief   : Directed self-checking bench for divider_32bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_32bit;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        dz;

  int r_total;
  int r_bad;

  divider_32bit u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .op     (op),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .result (result),
    .dz     (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] c_div  = 2'b00;
  localparam logic [1:0] c_divu = 2'b01;
  localparam logic [1:0] c_rem  = 2'b10;
  localparam logic [1:0] c_remu = 2'b11;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_total++;
    if (got !== exp) begin
      r_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One-cycle start pulse, then measure latency and check the done cycle
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_dz);
    int cyc;
    int busy_cyc;
    @(negedge clk);
    a = x; b = y; op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    cyc = 1;
    busy_cyc = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, cyc - 1, exp_lat);
    chk({tag, "_busy"}, busy_cyc, exp_lat);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_dz"}, {31'd0, dz}, {31'd0, exp_dz});
    @(negedge clk);
    chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    chk({tag, "_res_hold"}, result, exp_res);
  endtask

  initial begin
    int dones;
    r_total = 0;
    r_bad   = 0;
    rst_n = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0; op = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dz", {31'd0, dz}, 32'd0);
    rst_n = 1'b1;

    run_op("divu_100_7", c_divu, 32'd100, 32'd7, 33, 32'd14, 1'b0);
    run_op("remu_100_7", c_remu, 32'd100, 32'd7, 33, 32'd2, 1'b0);
    run_op("div_m7_2",   c_div,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2",   c_rem,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_7_m2",   c_rem,  32'd7, 32'hFFFF_FFFE, 33, 32'd1, 1'b0);
    run_op("div_m100_m7", c_div, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'd14, 1'b0);
    run_op("divu_5_0",   c_divu, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1'b1);
    run_op("remu_5_0",   c_remu, 32'd5, 32'd0, 1, 32'd5, 1'b1);
    run_op("div_m1_0",   c_div,  32'hFFFF_FFFF, 32'd0, 1, 32'hFFFF_FFFF, 1'b1);
    run_op("rem_m7_0",   c_rem,  32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, 1'b1);
    run_op("div_ovf",    c_div,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0);
    run_op("rem_ovf",    c_rem,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 1'b0);
    run_op("divu_ovf",   c_divu, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 1'b0);
    run_op("div_min_2",  c_div,  32'h8000_0000, 32'd2, 33, 32'hC000_0000, 1'b0);

    // Starts during CALC must be ignored
    @(negedge clk);
    a = 32'd1000; b = 32'd10; op = c_divu; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 1; i < 45; i++) begin
      if (i == 5 || i == 32) begin
        a = 32'd77; b = 32'd0; op = c_remu; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        chk("ign_res", result, 32'd100);
        chk("ign_dz", {31'd0, dz}, 32'd0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_done_count", dones, 1);

    // Reset mid-calculation aborts with no done
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'd3; op = c_divu; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", result, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", dones, 0);
    run_op("divu_big_3", c_divu, 32'hFFFF_FFFF, 32'd3, 33, 32'h5555_5555, 1'b0);

    $display("test done: total=%0d bad=%0d", r_total, r_bad);
    $finish;
  end

endmodule

`default_nettype wire
